prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
// - Boot-time writer for the instruction memory: receives a byte stream (valid/ready), packs it
//   little-endian into 32-bit instruction words and writes them at consecutive word addresses.
// - Holds the processor in reset (cpu_reset, drives the pc reset) for the whole load, then releases it.
// - Sits between the host/UART byte source and the instruction memory write port, beside the core.
// PARAMETERS
// - ADDR_W  6   word-address width of instruction memory; DEPTH = 2**ADDR_W words
// - WORD_W  32  instruction word width; fixed at 4 bytes, other values unsupported
// PORTS
// - clk         in   1         system clock, all state on posedge
// - reset       in   1         asynchronous, active-high reset
// - start       in   1         one-cycle pulse: begin load; sampled only in IDLE or DONE
// - num_words   in   ADDR_W+1  words to load, latched on accepted start
// - byte_valid  in   1         byte_data holds a valid byte
// - byte_data   in   8         stream byte
// - byte_ready  out  1         loader accepts a byte this cycle
// - imem_we     out  1         instruction memory write strobe (one cycle per word)
// - imem_addr   out  ADDR_W    word address of write
// - imem_wdata  out  WORD_W    assembled instruction
// - cpu_reset   out  1         reset to processor pc; 1 = held
// - busy        out  1         load in progress (COLLECT/WRITE/RELEASE)
// - done        out  1         load finished, processor running
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, cpu_reset=1, byte_ready=0, imem_we=0, imem_addr=0,
//   imem_wdata=0, busy=0, done=0, byte and word counters=0, partial word discarded.
// - Interface decided: one clock; reset is asynchronous and active-high.
// - FSM: IDLE, COLLECT, WRITE, RELEASE, DONE.
// - IDLE: cpu_reset=1. start -> latch n=min(num_words,DEPTH); n==0 -> RELEASE else COLLECT.
// - COLLECT: byte_ready=1; byte accepted when byte_valid&&byte_ready; byte k (0..3) -> bits
//   [8k+7:8k]; on 4th accepted byte -> WRITE next cycle. byte_valid while not ready: no effect.
// - WRITE: byte_ready=0; imem_we=1 exactly one cycle, imem_addr=word_cnt, imem_wdata=word.
//   Next: word_cnt+1==n -> RELEASE, else word_cnt++ and COLLECT. Addresses never wrap.
// - RELEASE: cpu_reset stays 1 for exactly 2 cycles, then DONE.
// - DONE: cpu_reset=0, done=1, busy=0. start -> restart as from IDLE (cpu_reset=1 next cycle).
// - Latency: last byte accepted at cycle t -> imem_we at t+1; cpu_reset falls at t+4.
// - start during COLLECT/WRITE/RELEASE: ignored. num_words changes after start: ignored.
// - num_words>DEPTH: saturated to DEPTH, all DEPTH words written, no error flag.
// - Reset mid-load: words already written stay in memory; no further writes; processor held.
// - imem_addr/imem_wdata hold last written value outside WRITE; imem_we=0 outside WRITE.
// STRUCTURE
// - Package loader_pkg: state enum (IDLE,COLLECT,WRITE,RELEASE,DONE), BYTES_PER_WORD=4,
//   RELEASE_CYCLES=2.
// - Sub-module byte_assembler: 2-bit byte counter + 32-bit little-endian shift/insert register,
//   inputs accept/clear, outputs word and word_full. Top holds FSM, word counter, release timer.
// TESTING
// - Reset then idle 10 cycles -> cpu_reset=1, byte_ready=0, imem_we never asserted.
// - start, num_words=2, bytes 13 05 00 00 93 05 10 00 back-to-back -> writes addr0=0x00000513,
//   addr1=0x00100593, imem_we one cycle each, cpu_reset falls 3 cycles after 2nd write, done=1.
// - Same load with byte_valid toggling every other cycle -> identical writes, only timing stretched.
// - start with num_words=0 -> no writes, cpu_reset low 3 cycles after start, done=1.
// - num_words=100 (ADDR_W=6) -> exactly 64 writes, addr 0..63, no wrap, then release.
// - Reset asserted after 2 bytes of word 1 -> no write of word 1, IDLE, cpu_reset=1; second start
//   while busy ignored; start in DONE reloads and reasserts cpu_reset next cycle.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and sizing constants for the program loader.
package loader_pkg;
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, RELEASE, DONE} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int RELEASE_CYCLES = 2;
endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: packs accepted bytes little-endian into a 32-bit word.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  byte_data,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic        word_full
);
    localparam int CW = $clog2(BYTES_PER_WORD);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8*BYTES_PER_WORD-1:0] word_q, word_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
    // Stale upper bytes need no clearing: every byte lane is rewritten before the word is used.
    always_comb begin
        cnt_d  = clear ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
        word_d = word_q;
        if (accept && !clear)
            word_d[{cnt_q, 3'b000} +: 8] = byte_data;
    end
    assign word      = word_q;
    assign word_full = accept && !clear && cnt_q == CW'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams bytes into instruction memory words and holds the core in reset
// until the load completes.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int WORD_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(2 ** ADDR_W);
    state_t state_q, state_d;
    logic [ADDR_W:0] n_q, n_d, word_cnt_q, word_cnt_d, n_req;
    logic [1:0] rel_cnt_q, rel_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] word;
    logic accept, clear, word_full;
    assign accept = byte_valid && byte_ready;
    assign clear  = start && (state_q == IDLE || state_q == DONE);
    assign n_req  = num_words > DEPTH_W ? DEPTH_W : num_words;
    byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .clear     (clear),
        .byte_data (byte_data),
        .word      (word),
        .word_full (word_full)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            word_cnt_q <= '0;
            rel_cnt_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        rel_cnt_d  = '0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d        = n_req;
                    word_cnt_d = '0;
                    state_d    = n_req == '0 ? RELEASE : COLLECT;
                end
            end
            COLLECT: state_d = word_full ? WRITE : COLLECT;
            WRITE: begin
                addr_d  = word_cnt_q[ADDR_W-1:0];
                wdata_d = word;
                if (word_cnt_q + 1'b1 == n_q) begin
                    state_d = RELEASE;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = COLLECT;
                end
            end
            RELEASE: begin
                rel_cnt_d = rel_cnt_q + 2'd1;
                state_d   = rel_cnt_q == 2'(RELEASE_CYCLES - 1) ? DONE : RELEASE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Address/data show the live word during WRITE and hold the last written value otherwise.
    always_comb begin
        byte_ready = state_q == COLLECT;
        imem_we    = state_q == WRITE;
        imem_addr  = imem_we ? word_cnt_q[ADDR_W-1:0] : addr_q;
        imem_wdata = imem_we ? word : wdata_q;
        cpu_reset  = state_q != DONE;
        busy       = state_q == COLLECT || state_q == WRITE || state_q == RELEASE;
        done       = state_q == DONE;
    end
endmodule
